alarm_trigger_ctrl: RTL and testbench
=====================================

# alarm_trigger_ctrl

Alarm sequencer that sits directly upstream of the buzzer beeper in the clock design. It compares the running BCD time against a programmed alarm time, then emits single-cycle `Buzzer_trigger` pulses at a fixed once-per-N-seconds cadence; each pulse starts one beep burst in the beeper. Stop and snooze key handling and an automatic timeout end the ringing.

## Interface
- `BEEP_PERIOD_S`, 2: `Sec_tick` count between successive triggers while ringing (1..255).
- `RING_COUNT`, 30: triggers per ringing episode before auto-timeout (1..255).
- `SNOOZE_S`, 300: `Sec_tick` count spent in snooze (1..65535).
- `SNOOZE_MAX`, 3: snoozes allowed per alarm event (0..15).
- `Clk_50MHz` in 1: system clock; all logic on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Sec_tick` in 1: one-cycle pulse once per second, from timekeeping.
- `Time_hour`, `Time_min`, `Time_sec` in 8 each: current time, packed BCD.
- `Alarm_hour`, `Alarm_min` in 8 each: alarm time, packed BCD.
- `Alarm_en` in 1: alarm armed (level).
- `Key_stop`, `Key_snooze` in 1: debounced key levels, active-high.
- `Buzzer_trigger` out 1: one-cycle pulse to the beeper.
- `Alarm_ringing` out 1: high in RINGING.
- `Alarm_snoozing` out 1: high in SNOOZE.

## Operation
- Reset: state IDLE; all outputs 0; all counters and edge registers 0.
- `match` = `Alarm_en` & hour==`Alarm_hour` & min==`Alarm_min` & sec==8'h00. It is registered each cycle; `match_rise` = match & ~match_q.
- Keys are rising-edge detected internally (registered). A held key acts only once.
- States:
  - IDLE: on `match_rise`, go to RINGING, pulse `Buzzer_trigger`, set pulses=1, tick_cnt=0, snoozes=0.
  - RINGING: each `Sec_tick` increments tick_cnt. When tick_cnt reaches `BEEP_PERIOD_S`: if pulses<`RING_COUNT`, pulse the trigger, increment pulses and clear tick_cnt; otherwise go to IDLE with no pulse.
  - RINGING, stop edge: go to IDLE.
  - RINGING, snooze edge with snoozes<`SNOOZE_MAX`: go to SNOOZE, increment snoozes, clear the 16-bit snooze counter. When snoozes==`SNOOZE_MAX`, the snooze edge is ignored.
  - SNOOZE: each `Sec_tick` increments the counter. At `SNOOZE_S`, go to RINGING with a trigger pulse, pulses=1, tick_cnt=0.
  - SNOOZE, stop edge: go to IDLE.
- Precedence, highest first: `Reset` > `Alarm_en` low (any state to IDLE next cycle, no pulse) > stop > snooze > `Sec_tick`.
- `match_rise` is ignored outside IDLE.
- No pulse is emitted in the cycle a state is exited by stop, snooze or disable.
- Counter compares are unsigned and saturate-free; the ranges above guarantee no wrap.

## Timing
- `Buzzer_trigger` is high exactly 1 cycle. Pulses are never back-to-back.
- Match to trigger: when `match` goes true in cycle N, `Buzzer_trigger` and `Alarm_ringing` are high in cycle N+1.
- Periodic trigger: high in the cycle after the `Sec_tick` that completes the period.
- Snooze edge to `Alarm_snoozing` high: 2 cycles (edge register plus state register).
- Stop edge to IDLE: 2 cycles.
- `Alarm_ringing` and `Alarm_snoozing` are registered and never high together.
- Asynchronous `Reset` mid-operation clears outputs immediately, with no trailing pulse.

## Configuration
- `HOURLY_CHIME_EN`:
  - Defined: in IDLE, with `Alarm_en` ignored, the rising edge of (min==8'h00 & sec==8'h00) emits one `Buzzer_trigger` pulse (1-cycle latency). No state change occurs and ringing outputs stay 0.
  - If `match_rise` occurs in the same cycle, the alarm path alone fires, giving a single pulse.
  - Undefined: no chime logic and no chime pulses.

## Test plan
- Params BEEP_PERIOD_S=2, RING_COUNT=3: time 07:30:00, alarm 07:30, `Alarm_en`=1 -> trigger at match+1, then after tick 2 and tick 4; `Alarm_ringing` falls after tick 6; 3 pulses total.
- While ringing, pulse `Key_snooze` and `Sec_tick` in the same cycle -> SNOOZE entered, tick ignored. SNOOZE_S=5: after the 5th tick, trigger pulses and `Alarm_ringing`=1.
- SNOOZE_MAX=2: three snooze presses across episodes -> third ignored, ringing continues to auto-timeout.
- Press `Key_stop` and `Key_snooze` together in RINGING -> IDLE, no further triggers, `Alarm_snoozing` stays 0.
- Assert `Reset` mid-RINGING, 3 cycles after a trigger -> all outputs 0 asynchronously; after release, no pulse until the next `match_rise`.
- With `HOURLY_CHIME_EN` defined and `Alarm_en`=0: time steps 08:59:59 to 09:00:00 -> exactly one trigger, `Alarm_ringing` stays 0. With the alarm also set to 09:00 and enabled -> exactly one trigger and ringing starts.

Source files
------------

// File: rtl/alarm_trigger_ctrl.sv
// rtl/alarm_trigger_ctrl.sv - alarm time compare and ring/snooze sequencer driving beeper trigger pulses
// Optional hourly chime in IDLE is built only when HOURLY_CHIME_EN is defined.
module alarm_trigger_ctrl #(
  parameter int unsigned BEEP_PERIOD_S = 2,
  parameter int unsigned RING_COUNT    = 30,
  parameter int unsigned SNOOZE_S      = 300,
  parameter int unsigned SNOOZE_MAX    = 3
) (
  input  logic       Clk_50MHz,
  input  logic       Reset,
  input  logic       Sec_tick,
  input  logic [7:0] Time_hour,
  input  logic [7:0] Time_min,
  input  logic [7:0] Time_sec,
  input  logic [7:0] Alarm_hour,
  input  logic [7:0] Alarm_min,
  input  logic       Alarm_en,
  input  logic       Key_stop,
  input  logic       Key_snooze,
  output logic       Buzzer_trigger,
  output logic       Alarm_ringing,
  output logic       Alarm_snoozing
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  localparam logic [7:0]  BEEP_P = BEEP_PERIOD_S[7:0];
  localparam logic [7:0]  RING_N = RING_COUNT[7:0];
  localparam logic [15:0] SNZ_S  = SNOOZE_S[15:0];
  localparam logic [3:0]  SNZ_N  = SNOOZE_MAX[3:0];

  state_t      state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic [7:0]  pulses_q, pulses_d;
  logic [15:0] scnt_q, scnt_d;
  logic [3:0]  snoozes_q, snoozes_d;
  logic        trig_q, trig_d;
  logic        match, match_q, match_rise;
  logic        stop_q, snz_key_q, stop_edge, snz_edge;

  assign match      = Alarm_en & (Time_hour == Alarm_hour) & (Time_min == Alarm_min)
                      & (Time_sec == 8'h00);
  assign match_rise = match & ~match_q;

`ifdef HOURLY_CHIME_EN
  logic top_of_hour, chime_q, chime_rise;
  assign top_of_hour = (Time_min == 8'h00) & (Time_sec == 8'h00);
  assign chime_rise  = top_of_hour & ~chime_q;

  always_ff @(posedge Clk_50MHz or posedge Reset) begin
    if (Reset) chime_q <= 1'b0;
    else       chime_q <= top_of_hour;
  end
`endif

  always_ff @(posedge Clk_50MHz or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      tick_q    <= 8'd0;
      pulses_q  <= 8'd0;
      scnt_q    <= 16'd0;
      snoozes_q <= 4'd0;
      trig_q    <= 1'b0;
      match_q   <= 1'b0;
      stop_q    <= 1'b0;
      snz_key_q <= 1'b0;
      stop_edge <= 1'b0;
      snz_edge  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      pulses_q  <= pulses_d;
      scnt_q    <= scnt_d;
      snoozes_q <= snoozes_d;
      trig_q    <= trig_d;
      match_q   <= match;
      stop_q    <= Key_stop;
      snz_key_q <= Key_snooze;
      stop_edge <= Key_stop & ~stop_q;
      snz_edge  <= Key_snooze & ~snz_key_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    pulses_d  = pulses_q;
    scnt_d    = scnt_q;
    snoozes_d = snoozes_q;
    trig_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (match_rise) begin
          state_d   = RINGING;
          trig_d    = 1'b1;
          pulses_d  = 8'd1;
          tick_d    = 8'd0;
          snoozes_d = 4'd0;
        end
`ifdef HOURLY_CHIME_EN
        else if (chime_rise) begin
          trig_d = 1'b1;
        end
`endif
      end
      RINGING: begin
        if (!Alarm_en || stop_edge) begin
          state_d = IDLE;
        end else if (snz_edge && (snoozes_q < SNZ_N)) begin
          state_d   = SNOOZE;
          snoozes_d = snoozes_q + 4'd1;
          scnt_d    = 16'd0;
        end else if (Sec_tick) begin
          // A limited snooze edge falls through here so the tick still counts.
          if (tick_q + 8'd1 == BEEP_P) begin
            if (pulses_q < RING_N) begin
              trig_d   = 1'b1;
              pulses_d = pulses_q + 8'd1;
              tick_d   = 8'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      SNOOZE: begin
        if (!Alarm_en || stop_edge) begin
          state_d = IDLE;
        end else if (Sec_tick) begin
          if (scnt_q + 16'd1 == SNZ_S) begin
            state_d  = RINGING;
            trig_d   = 1'b1;
            pulses_d = 8'd1;
            tick_d   = 8'd0;
          end else begin
            scnt_d = scnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Buzzer_trigger = trig_q;
  assign Alarm_ringing  = (state_q == RINGING);
  assign Alarm_snoozing = (state_q == SNOOZE);

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// tb/tb_alarm_trigger_ctrl.sv - directed vector bench for alarm_trigger_ctrl
module tb_alarm_trigger_ctrl;

  logic       Clk_50MHz = 1'b0;
  logic       Reset;
  logic       Sec_tick;
  logic [7:0] Time_hour, Time_min, Time_sec;
  logic [7:0] Alarm_hour, Alarm_min;
  logic       Alarm_en, Key_stop, Key_snooze;
  logic       Buzzer_trigger, Alarm_ringing, Alarm_snoozing;

  int n_checks = 0;
  int n_pass   = 0;
  int trig_cnt = 0;

  always #5 Clk_50MHz = ~Clk_50MHz;

  alarm_trigger_ctrl #(
    .BEEP_PERIOD_S(2),
    .RING_COUNT   (3),
    .SNOOZE_S     (5),
    .SNOOZE_MAX   (2)
  ) dut (
    .Clk_50MHz     (Clk_50MHz),
    .Reset         (Reset),
    .Sec_tick      (Sec_tick),
    .Time_hour     (Time_hour),
    .Time_min      (Time_min),
    .Time_sec      (Time_sec),
    .Alarm_hour    (Alarm_hour),
    .Alarm_min     (Alarm_min),
    .Alarm_en      (Alarm_en),
    .Key_stop      (Key_stop),
    .Key_snooze    (Key_snooze),
    .Buzzer_trigger(Buzzer_trigger),
    .Alarm_ringing (Alarm_ringing),
    .Alarm_snoozing(Alarm_snoozing)
  );

  typedef struct {
    logic       tick;
    logic [7:0] m;
    logic [7:0] s;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input logic tick);
    Sec_tick = tick;
    @(posedge Clk_50MHz);
    #1;
    Sec_tick = 1'b0;
    if (Buzzer_trigger) trig_cnt++;
  endtask

  function automatic logic [2:0] outs();
    return {Buzzer_trigger, Alarm_ringing, Alarm_snoozing};
  endfunction

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    Time_hour = h;
    Time_min  = m;
    Time_sec  = s;
  endtask

  task automatic start_alarm(input string name);
    set_time(8'h07, 8'h29, 8'h59);
    cyc(1'b0);
    set_time(8'h07, 8'h30, 8'h00);
    cyc(1'b0);
    check(name, outs(), 3'b110);
  endtask

  task automatic snooze_cycle(input string name);
    Key_snooze = 1'b1;
    cyc(1'b0);
    check({name, "_pre"}, outs(), 3'b010);
    cyc(1'b1);
    check({name, "_enter"}, outs(), 3'b001);
    Key_snooze = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1);
    check({name, "_hold"}, outs(), 3'b001);
    cyc(1'b1);
    check({name, "_return"}, outs(), 3'b110);
  endtask

  initial begin
    Reset = 1'b1;
    Sec_tick = 1'b0;
    Key_stop = 1'b0;
    Key_snooze = 1'b0;
    Alarm_en = 1'b1;
    Alarm_hour = 8'h07;
    Alarm_min = 8'h30;
    set_time(8'h07, 8'h29, 8'h59);

    tbl[0] = '{1'b0, 8'h29, 8'h59, 3'b000};
    tbl[1] = '{1'b0, 8'h30, 8'h00, 3'b110};
    tbl[2] = '{1'b1, 8'h30, 8'h00, 3'b010};
    tbl[3] = '{1'b0, 8'h30, 8'h00, 3'b010};
    tbl[4] = '{1'b1, 8'h30, 8'h00, 3'b110};
    tbl[5] = '{1'b1, 8'h30, 8'h00, 3'b010};
    tbl[6] = '{1'b1, 8'h30, 8'h00, 3'b110};
    tbl[7] = '{1'b1, 8'h30, 8'h00, 3'b010};
    tbl[8] = '{1'b1, 8'h30, 8'h00, 3'b000};
    tbl[9] = '{1'b1, 8'h30, 8'h01, 3'b000};

    cyc(1'b0);
    check("reset_state", outs(), 3'b000);
    Reset = 1'b0;

    trig_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_time(8'h07, tbl[i].m, tbl[i].s);
      cyc(tbl[i].tick);
      check($sformatf("ring_vec%0d", i), outs(), tbl[i].exp);
    end
    check("ring_pulse_total", trig_cnt, 3);

    start_alarm("snz_start");
    snooze_cycle("snz1");
    snooze_cycle("snz2");
    Key_snooze = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    check("snz3_ignored", outs(), 3'b010);
    Key_snooze = 1'b0;
    trig_cnt = 0;
    for (int i = 0; i < 6; i++) cyc(1'b1);
    check("snz_timeout_pulses", trig_cnt, 2);
    check("snz_timeout_idle", outs(), 3'b000);

    start_alarm("both_start");
    Key_stop = 1'b1;
    Key_snooze = 1'b1;
    cyc(1'b0);
    check("both_pre", outs(), 3'b010);
    cyc(1'b0);
    check("both_idle", outs(), 3'b000);
    Key_stop = 1'b0;
    Key_snooze = 1'b0;
    trig_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1);
      if (Alarm_snoozing) check("both_no_snooze", 1'b1, 1'b0);
    end
    check("both_no_trig", trig_cnt, 0);

    start_alarm("rst_start");
    for (int i = 0; i < 3; i++) cyc(1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_async", outs(), 3'b000);
    Time_min = 8'h31;
    @(posedge Clk_50MHz);
    #1;
    Reset = 1'b0;
    trig_cnt = 0;
    for (int i = 0; i < 6; i++) cyc(1'b1);
    check("rst_no_trig", trig_cnt, 0);
    check("rst_idle", outs(), 3'b000);

    start_alarm("dis_start");
    Alarm_en = 1'b0;
    cyc(1'b0);
    check("dis_idle", outs(), 3'b000);
    Time_min = 8'h31;
    cyc(1'b0);
    Alarm_en = 1'b1;
    trig_cnt = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1);
    check("dis_no_trig", trig_cnt, 0);

    Alarm_en = 1'b0;
    set_time(8'h08, 8'h59, 8'h59);
    cyc(1'b0);
    set_time(8'h09, 8'h00, 8'h00);
    trig_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      if (Alarm_ringing) check("chime_ring", 1'b1, 1'b0);
    end
`ifdef HOURLY_CHIME_EN
    check("chime_pulses", trig_cnt, 1);
`else
    check("chime_pulses", trig_cnt, 0);
`endif

    Alarm_hour = 8'h09;
    Alarm_min = 8'h00;
    Alarm_en = 1'b1;
    set_time(8'h08, 8'h59, 8'h59);
    cyc(1'b0);
    set_time(8'h09, 8'h00, 8'h00);
    trig_cnt = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0);
    check("chime_alarm_pulses", trig_cnt, 1);
    check("chime_alarm_ring", outs(), 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
